// File: rtl/fib_pkg.sv
// Shared constants, FSM state encoding and the saturation helper for the
// Fibonacci scheduler and its engine.
package fib_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int FIB_W_DEF = 20;
    localparam int NUM_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // All-ones value of a w-bit result, returned 64 bits wide for the caller to narrow.
    function automatic logic [63:0] fib_sat(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction
endpackage

// File: rtl/fib_sched_if.sv
// Request/response channel between client blocks and the Fibonacci scheduler.
interface fib_sched_if #(
    parameter int N_REQ = 4,
    parameter int NUM_W = 8,
    parameter int FIB_W = 20,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*NUM_W-1:0] req_num;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [FIB_W-1:0]       rsp_value;
    logic                   rsp_ovf;
    logic                   busy;

    modport master (
        output req_valid, req_num, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_value, rsp_ovf, busy
    );

    modport slave (
        input  req_valid, req_num, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_value, rsp_ovf, busy
    );
endinterface

// File: rtl/fib_engine.sv
// Iterative Fibonacci engine: one a/b step per cycle with sticky overflow
// tracking; the result is saturated to all-ones once F(n) no longer fits.
module fib_engine
    import fib_pkg::*;
#(
    parameter int FIB_W = FIB_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_n,
    output logic             o_done,
    output logic [FIB_W-1:0] o_value,
    output logic             o_ovf
);
    localparam logic [FIB_W-1:0] SAT = FIB_W'(fib_sat(FIB_W));

    logic [FIB_W-1:0] r_a, r_b;
    logic [NUM_W-1:0] r_k, r_n;
    logic             r_run, r_a_ovf, r_b_ovf;
    logic [FIB_W:0]   w_sum;
    logic             w_done;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_done = r_run && (r_k == r_n - NUM_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_run   <= 1'b0;
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
        end else if (i_start) begin
            r_a     <= '0;
            r_b     <= FIB_W'(1);
            r_k     <= '0;
            r_n     <= i_n;
            r_run   <= (i_n != '0);
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
        end else if (r_run) begin
            // b carries the lookahead term, so its overflow reaches a one step later
            r_a     <= r_b;
            r_b     <= w_sum[FIB_W-1:0];
            r_k     <= r_k + NUM_W'(1);
            r_b_ovf <= r_b_ovf | r_a_ovf | w_sum[FIB_W];
            r_a_ovf <= r_b_ovf;
            if (w_done) r_run <= 1'b0;
        end
    end

    assign o_done  = w_done;
    assign o_value = r_a_ovf ? SAT : r_a;
    assign o_ovf   = r_a_ovf;
endmodule

// File: rtl/fib_sched.sv
// Round-robin scheduler sharing one Fibonacci engine among N_REQ requesters;
// results return tagged with the requester ID on a valid/ready channel.
module fib_sched
    import fib_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int FIB_W = FIB_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic clock,
    input  logic reset,
    fib_sched_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           r_state, w_next;
    logic [ID_W-1:0]  r_rr_ptr, r_id, w_gnt_id, w_ptr_nxt;
    logic             w_gnt_vld, w_hs, w_eng_done, w_eng_ovf;
    logic [NUM_W-1:0] w_n;
    logic [FIB_W-1:0] w_eng_val;

    // Scan from the highest offset down so the closest valid requester to rr_ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_id  = '0;
        w_gnt_vld = 1'b0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = int'(r_rr_ptr) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (bus.req_valid[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ID_W'(idx);
            end
        end
    end

    assign w_hs      = (r_state == IDLE) && w_gnt_vld;
    assign w_n       = bus.req_num[int'(w_gnt_id)*NUM_W +: NUM_W];
    assign w_ptr_nxt = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_id     <= '0;
        end else begin
            r_state <= w_next;
            if (w_hs) r_id <= w_gnt_id;
            if (r_state == DONE && bus.rsp_ready) r_rr_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = (w_n == '0) ? DONE : RUN;
            RUN:     if (w_eng_done) w_next = DONE;
            DONE:    if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    fib_engine #(.FIB_W(FIB_W), .NUM_W(NUM_W)) u_engine (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_hs),
        .i_n     (w_n),
        .o_done  (w_eng_done),
        .o_value (w_eng_val),
        .o_ovf   (w_eng_ovf)
    );

    assign bus.req_ready = w_hs ? (N_REQ'(1) << w_gnt_id) : '0;
    assign bus.rsp_valid = (r_state == DONE);
    assign bus.rsp_id    = (r_state == DONE) ? r_id : '0;
    assign bus.rsp_value = (r_state == DONE) ? w_eng_val : '0;
    assign bus.rsp_ovf   = (r_state == DONE) ? w_eng_ovf : 1'b0;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: doc/fib_sched.md
Name: fib_sched

Overview:
Shared-resource scheduler for the Fibonacci datapath. Up to N_REQ requesters each ask for the n-th Fibonacci number. Requests are arbitrated round-robin onto one iterative engine, and each result is returned tagged with the requester ID over a valid/ready response channel. The block sits between client blocks and the single Fibonacci engine instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
FIB_W, 20, result width
NUM_W, 8, width of requested index n

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_num  in  N_REQ*NUM_W  per-requester index n; requester i occupies bits [i*NUM_W +: NUM_W]
req_ready  out  N_REQ  one-hot accept; at most one bit high
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  clog2(N_REQ)  requester ID of the result
rsp_value  out  FIB_W  F(n), saturated
rsp_ovf  out  1  F(n) exceeded FIB_W bits
busy  out  1  high in RUN or DONE

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0 during and after reset, state is IDLE, and the round-robin pointer is 0.
- Definition: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - Grant goes to the first requester with req_valid high, searching from rr_ptr upward with wrap.
  - req_ready[g] is high combinationally for that winner only. When no request is valid, req_ready is all zero.
  - Handshake = req_valid[g] & req_ready[g]. On the handshake, latch id=g and n, set a=0, b=1, k=0, clear both overflow flags.
  - Next state is DONE if n==0, otherwise RUN.
- RUN, each cycle:
  - a<=b and b<=a+b, computed FIB_W+1 bits wide; k<=k+1.
  - When k==n-1, go to DONE.
- Overflow tracking:
  - b_ovf <= b_ovf | a_ovf | carry-out of a+b.
  - a_ovf <= b_ovf.
- DONE:
  - rsp_valid=1.
  - rsp_value = a_ovf ? all-ones : a; rsp_ovf = a_ovf; rsp_id = latched id.
  - Outputs hold stable while rsp_ready is low.
  - On rsp_valid & rsp_ready: go to IDLE and set rr_ptr <= id+1 (wrap at N_REQ).
- Latency: with the handshake in cycle t, rsp_valid first rises at t+1 when n==0 and at t+1+n otherwise.
- req_ready is 0 in RUN and DONE. Requests arriving then wait. A requester may drop req_valid before its handshake with no effect.
- Requester inputs are sampled only at the handshake. Changing req_num afterwards does not affect the running computation.
- In DONE, rsp_ready together with a new req_valid accepts no new request in that same cycle. The new request is granted from IDLE in the next cycle.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. The pending result is discarded, with no rsp_valid.
- Largest in-range value: F(30)=832040 for FIB_W=20. Any n>=31 returns 0xFFFFF with rsp_ovf=1. n up to 255 must terminate normally, taking n cycles.

Decomposition:
- Package fib_pkg holds:
  - FIB_W/NUM_W default constants
  - the FSM state enum (IDLE, RUN, DONE)
  - a function returning the saturation constant
- Natural sub-module fib_engine holds the a/b/k registers, the overflow flags and the termination compare. Its ports are start, n, done, value and ovf.
- fib_sched keeps the arbiter, rr_ptr, id latch, FSM and response channel.

Test Plan:
- Reset asserted mid-stream, then released: all outputs 0, req_ready follows req_valid[0] on the first cycle, and rr_ptr=0.
- Single request id=2, n=10, rsp_ready=1: handshake at t, rsp_valid at t+11 with rsp_value=55, rsp_id=2, rsp_ovf=0. Then n=0 gives 0 at t+1, and n=1 gives 1 at t+2.
- Boundary: n=30 gives 832040 with ovf=0. n=31 gives 0xFFFFF with ovf=1. n=255 gives 0xFFFFF with ovf=1 after 255 RUN cycles.
- All 4 requesters valid continuously with distinct n: grants in order 0,1,2,3,0 with matching rsp_id, and req_ready is never more than one bit.
- Backpressure: rsp_ready held low 5 cycles in DONE. rsp_valid, rsp_value and rsp_id stay stable and no req_ready is asserted. Release gives one transfer, then IDLE.
- Reset pulse during RUN for n=20: no rsp_valid. After reset, a fresh request n=20 returns 6765.
